// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: operand width, FSM encoding
// and the quotient value reported on a zero divisor.
package div_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{1'b1}};

endpackage

// File: rtl/div16_seq_prefix_add.sv
// Kogge-Stone parallel-prefix adder used for the divider's trial subtraction
// (a + ~b + 1); cout doubles as the "no borrow" flag.
module Prefix_Add16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int LV = $clog2(W);

    logic [LV:0][W-1:0]   g;
    logic [LV-1:0][W-1:0] p;
    logic [W-1:0]         p0;
    logic [W-1:0]         carry;

    assign p0   = a ^ b;
    assign p[0] = p0;
    // Carry-in folded into bit 0's generate so the prefix tree needs no extra column.
    assign g[0] = (a & b) | {{(W-1){1'b0}}, p0[0] & cin};

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int DIST = 1 << l;
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= DIST) begin : g_comb
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-DIST]);
                if (l + 1 < LV) begin : g_p
                    assign p[l+1][i] = p[l][i] & p[l][i-DIST];
                end
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                if (l + 1 < LV) begin : g_p
                    assign p[l+1][i] = p[l][i];
                end
            end
        end
    end

    assign carry = {g[LV][W-2:0], cin};
    assign sum   = p0 ^ carry;
    assign cout  = g[LV][W-1];

endmodule

// File: rtl/div16_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock,
// with a start/busy/done handshake and result packed as {remainder, quotient}.
module div16_seq
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] OUT,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [2*WIDTH-1:0] out_q;
    logic             dbz_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic             ge;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] q_d;

    assign rem_sh = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};

    Prefix_Add16 #(.W(WIDTH)) u_sub (
        .a    (rem_sh[WIDTH-1:0]),
        .b    (~d_q),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // A set top bit means the shifted remainder already exceeds any divisor.
    assign ge = rem_sh[WIDTH] | no_borrow;

    always_comb begin
        rem_d = rem_sh;
        q_d   = {q_q[WIDTH-2:0], ge};
        if (ge) begin
            rem_d = {1'b0, diff};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start && (B != '0)) begin
                        q_q     <= A;
                        d_q     <= B;
                        rem_q   <= '0;
                        count_q <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (start) begin
                        out_q   <= {A, DBZ_QUOT};
                        dbz_q   <= 1'b1;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    q_q     <= q_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        out_q   <= {rem_d[WIDTH-1:0], q_d};
                        dbz_q   <= 1'b0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign OUT         = out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/div16_seq.md
Name: div16_seq

Overview:
- Sequential unsigned 16-bit divider; it performs the inverse of the datapath's 16x16 multiply.
- Accepts dividend/divisor on a start pulse and runs a restoring shift-subtract loop, one quotient bit per clock.
- Returns quotient and remainder packed into a 32-bit result, matching the 32-bit width of the ALU result bus.
- Sits beside the ALU as a multi-cycle functional unit under a start/busy/done handshake.

Parameters:
- WIDTH, 16: operand width. The quotient and remainder are each WIDTH bits, and the iteration count equals WIDTH.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the unit is not busy.
- A  input  16  dividend; captured on an accepted start.
- B  input  16  divisor; captured on an accepted start.
- busy  output  1  high while iterating (state RUN).
- done  output  1  single-cycle pulse; OUT and div_by_zero are valid from this cycle onward.
- OUT  output  32  {remainder[15:0], quotient[15:0]}.
- div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; OUT=0; div_by_zero=0; internal count/shift registers=0. Reset mid-operation aborts the division; no done pulse is produced.
- FSM states: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- IDLE or DONE with start=1 and B!=0:
  - Capture dividend into the quotient shift register q and the divisor into d.
  - Set rem=0 (17 bits) and count=0, then go to RUN.
- IDLE or DONE with start=1 and B==0:
  - Go directly to DONE with OUT={A, 16'hFFFF} and div_by_zero=1.
  - The done pulse appears after 1 edge.
- DONE with start=0: go to IDLE. Back-to-back starts from DONE are accepted.
- RUN, each edge:
  - rem_sh = {rem[15:0], q[15]}; q <= q<<1.
  - Trial difference diff = rem_sh[15:0] - d.
  - ge = rem_sh[16] | no_borrow.
  - If ge: rem <= {1'b0, diff}, q[0] <= 1.
  - Else: rem <= rem_sh, q[0] <= 0.
  - count <= count+1.
  - On the edge where count==WIDTH-1, go to DONE and register OUT={rem_next[15:0], q_next} and div_by_zero=0.
- Latency: start sampled at edge t0, 16 RUN edges (t1..t16), done high for the cycle after t16, i.e. 17 cycles start-to-done.
- start while busy=1 is ignored; captured operands are unaffected. A/B changes during RUN have no effect.
- OUT and div_by_zero hold their last values until the next completion or reset. They are not cleared on start.
- Arithmetic is unsigned only; there is no overflow case for B!=0 (quotient <= dividend < 2^16).

Decomposition:
- Shared package (div_pkg):
  - WIDTH constant.
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Divide-by-zero quotient constant (all ones).
- Sub-module: the trial subtraction is one Prefix_Add16 instance.
  - Inputs: a = rem_sh[15:0], b = ~d, cin = 1.
  - Outputs: sum = diff, cout = no_borrow.
- The FSM, counter and shift registers stay in div16_seq.

Test Plan:
1. A=100, B=7, start 1 cycle -> busy for 16 cycles; done at cycle 17; OUT={16'd2, 16'd14}; div_by_zero=0.
2. A=16'hFFFF, B=16'd1 -> OUT={16'h0000, 16'hFFFF}. A=16'hFFFF, B=16'hFFFF -> OUT={16'h0000, 16'h0001}. Covers the rem_sh[16] carry path.
3. A=3, B=10 -> OUT={16'd3, 16'd0}. A=0, B=5 -> OUT=0.
4. A=5, B=0 -> done after 1 cycle; OUT={16'd5, 16'hFFFF}; div_by_zero=1. A following 40/8 division clears div_by_zero and gives OUT={0, 5}.
5. Start 100/7, re-pulse start with A=9, B=3 at cycle 5 -> ignored; result is still {2, 14} at cycle 17. Start asserted in the done cycle with 50/6 -> accepted; done 17 cycles later with {2, 8}.
6. Start 100/7, assert rst at cycle 8 -> immediately state=IDLE, busy=0, OUT=0; no done pulse. A new start after rst deasserts completes normally.
